video_cap_wr: RTL and testbench
===============================

Name: video_cap_wr

Overview:
- Capture-side writer for the video line buffer. The display-side reader fetches 12-bit RGB444 words from this buffer by line index and column.
- Takes a pixel-strobed RGB444 source with hsync/vsync, skips a programmable start offset in X and Y, and writes a window into the buffer.
- Each write carries (o_line_idx, o_column, o_wdata); completed lines and frames are signalled by single-cycle pulses.

Parameters:
- PIX_W, 12, pixel word width (R[11:8], G[7:4], B[3:0]).
- COL_W, 9, column address width; max window width 2^COL_W.
- LINE_W, 9, line address width; max window height 2^LINE_W.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_enable  in  1  capture enable; low forces IDLE.
- i_pix_en  in  1  source pixel strobe (clock enable), one pixel per high cycle.
- i_hsync  in  1  line sync, active-high, already synchronous to i_clk.
- i_vsync  in  1  frame sync, active-high, already synchronous to i_clk.
- i_rgb  in  PIX_W  source pixel, valid when i_pix_en=1.
- i_x_start  in  12  pixels skipped after hsync before column 0.
- i_y_start  in  12  lines skipped after vsync before line 0.
- i_x_win_size  in  12  captured width in pixels.
- i_y_win_size  in  12  captured height in lines.
- o_we  out  1  buffer write strobe.
- o_line_idx  out  LINE_W  write line address.
- o_column  out  COL_W  write column address.
- o_wdata  out  PIX_W  write data.
- o_line_end  out  1  one-cycle pulse, line complete.
- o_frame_end  out  1  one-cycle pulse, frame complete.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; sync history registers 0.
- Edge detect: hs_rise = i_hsync & ~hs_d; vs_rise = i_vsync & ~vs_d; hs_d and vs_d are registered every cycle.
- Effective sizes:
  - xs = min(i_x_win_size, 2^COL_W).
  - ys = min(i_y_win_size, 2^LINE_W).
  - If xs=0 or ys=0, the block stays in WAIT_VS and never writes.
- States: IDLE, WAIT_VS, WAIT_HS, H_SKIP, ACTIVE, LINE_END.
- Global priority: i_enable=0 → IDLE next cycle. Otherwise vs_rise in any non-IDLE state → WAIT_HS with vcnt=0, line=0. A vs_rise does not pulse o_frame_end. An hs_rise in the same cycle as vs_rise is ignored.
- IDLE: if i_enable=1 → WAIT_VS.
- WAIT_VS: wait for vs_rise.
- WAIT_HS, on hs_rise:
  - If vcnt == i_y_start → H_SKIP with hcnt=0.
  - Else vcnt++.
  - Net effect: the i_y_start-th hsync after vsync (0-based) becomes line 0.
- H_SKIP: pixel strobes are counted in cycles strictly after the hs_rise cycle. On i_pix_en:
  - If hcnt < i_x_start, hcnt++.
  - Else write this pixel as column 0, col=1; go ACTIVE, or LINE_END if xs=1.
- ACTIVE, on i_pix_en: write the pixel at column col, then col++. The pixel at col == xs-1 is the last one; next state LINE_END.
- Early line end: hs_rise in ACTIVE or H_SKIP → LINE_END, with a pending new-line flag set and vcnt++. Strobes during that LINE_END cycle count into hcnt of the new line.
- LINE_END (one cycle):
  - o_line_end=1 and o_line_idx still holds the completed line.
  - line++.
  - If the completed line == ys-1: o_frame_end=1 in the same cycle as o_line_end, then → WAIT_VS. This takes priority over the pending flag.
  - Else → H_SKIP if the pending flag is set, otherwise → WAIT_HS.
- Write timing: latency 1. o_we=1 in the cycle after the qualifying i_pix_en, with o_wdata = the sampled i_rgb and o_column/o_line_idx = the addresses at sampling time. o_we=0 otherwise. o_wdata and o_column hold their last values when o_we=0.
- Line advance: o_line_idx updates to the new line on the cycle after LINE_END.
- Counter widths: hcnt and vcnt are 12 bits and saturate at 4095 (no wrap). col is COL_W+1 bits internally.
- Reset mid-operation: outputs go to 0 immediately (asynchronous). Capture resumes only after a new vs_rise.
- Enable drop mid-line: no o_line_end or o_frame_end pulse; any write already registered completes.

Test Plan:
- x_start=2, y_start=1, x_win=4, y_win=2; pix_en every cycle; 10-pixel lines → 8 writes: line 0 cols 0..3 = pixels 2..5 of hsync#1, line 1 = pixels 2..5 of hsync#2. Two o_line_end pulses; o_frame_end coincident with the second.
- x_win=8, hsync arrives after 5 captured pixels → o_line_end after col 4, line 0. Next line captured with line_idx=1 from col 0.
- vsync rise after line 0 completes, with y_win=4 → no o_frame_end. Next capture restarts at line_idx=0, col=0.
- i_enable low during ACTIVE → o_we=0 from 2 cycles later, no pulses. Re-enable with no vsync → no writes.
- i_rst_n low mid-ACTIVE → all outputs 0 in the same cycle, independent of clock.
- x_win=600, lines of 700 pixels → columns 0..511 written, then o_line_end. No write with column ≥512.

Source files
------------

// File: rtl/video_cap_wr.sv
// Capture-side writer for the video line buffer: windows a pixel-strobed RGB444
// stream by hsync/vsync offsets and emits buffer writes plus line/frame pulses.
module video_cap_wr #(
  parameter int PIX_W  = 12,
  parameter int COL_W  = 9,
  parameter int LINE_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_pix_en,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic [PIX_W-1:0]  i_rgb,
  input  logic [11:0]       i_x_start,
  input  logic [11:0]       i_y_start,
  input  logic [11:0]       i_x_win_size,
  input  logic [11:0]       i_y_win_size,
  output logic              o_we,
  output logic [LINE_W-1:0] o_line_idx,
  output logic [COL_W-1:0]  o_column,
  output logic [PIX_W-1:0]  o_wdata,
  output logic              o_line_end,
  output logic              o_frame_end
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_VS  = 3'd1,
    WAIT_HS  = 3'd2,
    H_SKIP   = 3'd3,
    ACTIVE   = 3'd4,
    LINE_END = 3'd5
  } state_t;

  localparam logic [11:0]       COL_MAX  = 12'(1 << COL_W);
  localparam logic [11:0]       LINE_MAX = 12'(1 << LINE_W);
  localparam logic [COL_W:0]    COL_ONE  = (COL_W+1)'(1);
  localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  state_t            state_r;
  logic              hs_d_r, vs_d_r;
  logic [11:0]       hcnt_r, vcnt_r;
  logic [COL_W:0]    col_r;
  logic [LINE_W-1:0] line_r;
  logic              pend_r;

  logic        hs_rise_s, vs_rise_s, size_zero_s, col_last_s, line_last_s;
  logic [11:0] xs_s, ys_s;

  assign hs_rise_s   = i_hsync & ~hs_d_r;
  assign vs_rise_s   = i_vsync & ~vs_d_r;
  assign xs_s        = (i_x_win_size > COL_MAX)  ? COL_MAX  : i_x_win_size;
  assign ys_s        = (i_y_win_size > LINE_MAX) ? LINE_MAX : i_y_win_size;
  assign size_zero_s = (xs_s == 12'd0) | (ys_s == 12'd0);
  assign col_last_s  = (12'(col_r) == xs_s - 12'd1);
  assign line_last_s = (12'(line_r) == ys_s - 12'd1);
  assign o_line_idx  = line_r;

  // Sync history for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_d_r <= 1'b0;
      vs_d_r <= 1'b0;
    end else begin
      hs_d_r <= i_hsync;
      vs_d_r <= i_vsync;
    end
  end

  // Capture FSM with counters and registered write/pulse outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      hcnt_r      <= 12'd0;
      vcnt_r      <= 12'd0;
      col_r       <= {(COL_W+1){1'b0}};
      line_r      <= {LINE_W{1'b0}};
      pend_r      <= 1'b0;
      o_we        <= 1'b0;
      o_column    <= {COL_W{1'b0}};
      o_wdata     <= {PIX_W{1'b0}};
      o_line_end  <= 1'b0;
      o_frame_end <= 1'b0;
    end else begin
      o_we        <= 1'b0;
      o_line_end  <= 1'b0;
      o_frame_end <= 1'b0;
      if (!i_enable) begin
        state_r <= IDLE;
      end else if (state_r == IDLE) begin
        state_r <= WAIT_VS;
      end else if (size_zero_s) begin
        state_r <= WAIT_VS;
        pend_r  <= 1'b0;
      end else if (vs_rise_s) begin
        state_r <= WAIT_HS;
        vcnt_r  <= 12'd0;
        line_r  <= {LINE_W{1'b0}};
        pend_r  <= 1'b0;
      end else if (hs_rise_s && (state_r == H_SKIP || state_r == ACTIVE)) begin
        // Early hsync: close this line, and the new line starts counting now.
        state_r     <= LINE_END;
        pend_r      <= 1'b1;
        vcnt_r      <= sat_inc(vcnt_r);
        hcnt_r      <= 12'd0;
        o_line_end  <= 1'b1;
        o_frame_end <= line_last_s;
      end else begin
        case (state_r)
          WAIT_VS: state_r <= WAIT_VS;
          WAIT_HS: begin
            if (hs_rise_s) begin
              if (vcnt_r == i_y_start) begin
                state_r <= H_SKIP;
                hcnt_r  <= 12'd0;
              end else begin
                vcnt_r <= sat_inc(vcnt_r);
              end
            end
          end
          H_SKIP: begin
            if (i_pix_en) begin
              if (hcnt_r < i_x_start) begin
                hcnt_r <= sat_inc(hcnt_r);
              end else begin
                o_we     <= 1'b1;
                o_column <= {COL_W{1'b0}};
                o_wdata  <= i_rgb;
                col_r    <= COL_ONE;
                if (xs_s == 12'd1) begin
                  state_r     <= LINE_END;
                  o_line_end  <= 1'b1;
                  o_frame_end <= line_last_s;
                end else begin
                  state_r <= ACTIVE;
                end
              end
            end
          end
          ACTIVE: begin
            if (i_pix_en) begin
              o_we     <= 1'b1;
              o_column <= col_r[COL_W-1:0];
              o_wdata  <= i_rgb;
              col_r    <= col_r + COL_ONE;
              if (col_last_s) begin
                state_r     <= LINE_END;
                o_line_end  <= 1'b1;
                o_frame_end <= line_last_s;
              end
            end
          end
          LINE_END: begin
            line_r <= line_r + LINE_ONE;
            pend_r <= 1'b0;
            if (i_pix_en) begin
              hcnt_r <= sat_inc(hcnt_r);
            end
            if (line_last_s) begin
              state_r <= WAIT_VS;
            end else if (pend_r) begin
              state_r <= H_SKIP;
            end else begin
              state_r <= WAIT_HS;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_cap_wr.sv
// Directed bench for video_cap_wr: windowing, early hsync, vsync restart,
// enable drop, async reset and column clamping.
module tb_video_cap_wr;

  logic        clk = 1'b0;
  logic        rst_n, enable, pix_en, hsync, vsync;
  logic [11:0] rgb, x_start, y_start, x_win, y_win;
  logic        we, line_end, frame_end;
  logic [8:0]  line_idx, column;
  logic [11:0] wdata;

  int n_checks = 0;
  int n_fail   = 0;

  int wr_line[$];
  int wr_col[$];
  int wr_data[$];
  int le_line[$];
  int fe_cnt;
  int fe_bad;

  always #5 clk = ~clk;

  video_cap_wr dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_pix_en(pix_en),
    .i_hsync(hsync), .i_vsync(vsync), .i_rgb(rgb),
    .i_x_start(x_start), .i_y_start(y_start),
    .i_x_win_size(x_win), .i_y_win_size(y_win),
    .o_we(we), .o_line_idx(line_idx), .o_column(column), .o_wdata(wdata),
    .o_line_end(line_end), .o_frame_end(frame_end)
  );

  // Record every write and pulse seen mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        wr_line.push_back(int'(line_idx));
        wr_col.push_back(int'(column));
        wr_data.push_back(int'(wdata));
      end
      if (line_end) le_line.push_back(int'(line_idx));
      if (frame_end) fe_cnt++;
      if (frame_end && !line_end) fe_bad++;
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int id, input int p);
    return (id * 256 + p) % 4096;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_line.delete(); wr_col.delete(); wr_data.delete(); le_line.delete();
    fe_cnt = 0;
    fe_bad = 0;
  endtask

  task automatic set_win(input int xs, input int ys, input int xw, input int yw);
    x_start = 12'(xs); y_start = 12'(ys); x_win = 12'(xw); y_win = 12'(yw);
  endtask

  task automatic vs_pulse();
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
  endtask

  // hsync cycle, npix strobed pixels, then two quiet cycles
  task automatic line_gen(input int npix, input int id);
    hsync = 1'b1; pix_en = 1'b0; tick();
    hsync = 1'b0;
    for (int p = 0; p < npix; p++) begin
      pix_en = 1'b1; rgb = 12'(pix(id, p)); tick();
    end
    pix_en = 1'b0; tick(); tick();
  endtask

  task automatic check_writes(input string tag, input int k, input int ln,
                              input int col, input int data);
    if (k < wr_line.size()) begin
      check_eq({tag, "_line"}, wr_line[k], ln);
      check_eq({tag, "_col"},  wr_col[k],  col);
      check_eq({tag, "_data"}, wr_data[k], data);
    end
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; enable = 1'b0; pix_en = 1'b0; hsync = 1'b0; vsync = 1'b0;
    rgb = 12'd0;
    set_win(0, 0, 0, 0);
    clear_log();
    tick(); tick();
    check_eq("rst_we", int'(we), 0);
    check_eq("rst_line_idx", int'(line_idx), 0);
    check_eq("rst_column", int'(column), 0);
    check_eq("rst_wdata", int'(wdata), 0);
    check_eq("rst_line_end", int'(line_end), 0);
    check_eq("rst_frame_end", int'(frame_end), 0);
    rst_n = 1'b1; enable = 1'b1;
    tick(); tick();

    // 1: basic window, y_start=1 skips hsync#0
    set_win(2, 1, 4, 2);
    clear_log();
    vs_pulse();
    for (int id = 0; id < 4; id++) line_gen(10, id);
    check_eq("t1_nwr", wr_line.size(), 8);
    for (int k = 0; k < 8; k++) check_writes("t1", k, k / 4, k % 4, pix(1 + k / 4, 2 + k % 4));
    check_eq("t1_nle", le_line.size(), 2);
    if (le_line.size() == 2) begin
      check_eq("t1_le0_line", le_line[0], 0);
      check_eq("t1_le1_line", le_line[1], 1);
    end
    check_eq("t1_nfe", fe_cnt, 1);
    check_eq("t1_fe_coinc", fe_bad, 0);

    // 2: early hsync after 5 captured pixels
    set_win(0, 0, 8, 2);
    clear_log();
    vs_pulse();
    hsync = 1'b1; tick(); hsync = 1'b0;
    for (int p = 0; p < 5; p++) begin
      pix_en = 1'b1; rgb = 12'(pix(5, p)); tick();
    end
    pix_en = 1'b0; hsync = 1'b1; tick();
    hsync = 1'b0; tick();
    for (int q = 0; q < 8; q++) begin
      pix_en = 1'b1; rgb = 12'(pix(6, q)); tick();
    end
    pix_en = 1'b0; tick(); tick();
    check_eq("t2_nwr", wr_line.size(), 13);
    for (int k = 0; k < 5; k++) check_writes("t2a", k, 0, k, pix(5, k));
    for (int k = 0; k < 8; k++) check_writes("t2b", 5 + k, 1, k, pix(6, k));
    check_eq("t2_nle", le_line.size(), 2);
    if (le_line.size() == 2) begin
      check_eq("t2_le0_line", le_line[0], 0);
      check_eq("t2_le1_line", le_line[1], 1);
    end
    check_eq("t2_nfe", fe_cnt, 1);

    // 3: vsync after line 0 restarts at line 0 with no frame_end
    set_win(0, 0, 2, 4);
    clear_log();
    vs_pulse();
    line_gen(4, 7);
    vs_pulse();
    line_gen(4, 8);
    check_eq("t3_nwr", wr_line.size(), 4);
    check_writes("t3a0", 0, 0, 0, pix(7, 0));
    check_writes("t3a1", 1, 0, 1, pix(7, 1));
    check_writes("t3b0", 2, 0, 0, pix(8, 0));
    check_writes("t3b1", 3, 0, 1, pix(8, 1));
    check_eq("t3_nle", le_line.size(), 2);
    check_eq("t3_nfe", fe_cnt, 0);

    // 4: enable drop mid-line, then re-enable without vsync
    set_win(0, 0, 8, 2);
    vs_pulse();
    clear_log();
    hsync = 1'b1; tick(); hsync = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pix_en = 1'b1; rgb = 12'(pix(9, p)); tick();
    end
    enable = 1'b0; rgb = 12'(pix(9, 3)); tick();
    tick();
    check_eq("t4_we_off", int'(we), 0);
    tick();
    check_eq("t4_we_off2", int'(we), 0);
    pix_en = 1'b0; tick();
    check_eq("t4_nwr", wr_line.size(), 3);
    check_writes("t4_last", 2, 0, 2, pix(9, 2));
    check_eq("t4_nle", le_line.size(), 0);
    check_eq("t4_nfe", fe_cnt, 0);
    enable = 1'b1; tick();
    line_gen(6, 10);
    check_eq("t4_reen_nwr", wr_line.size(), 3);

    // 5: async reset during ACTIVE
    set_win(0, 0, 8, 2);
    vs_pulse();
    hsync = 1'b1; tick(); hsync = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pix_en = 1'b1; rgb = 12'(pix(11, p)); tick();
    end
    check_eq("t5_pre_we", int'(we), 1);
    check_eq("t5_pre_col", int'(column), 2);
    check_eq("t5_pre_data", int'(wdata), pix(11, 2));
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_we", int'(we), 0);
    check_eq("t5_rst_col", int'(column), 0);
    check_eq("t5_rst_data", int'(wdata), 0);
    check_eq("t5_rst_line", int'(line_idx), 0);
    pix_en = 1'b0; tick(); tick();
    rst_n = 1'b1; tick();
    clear_log();
    line_gen(6, 12);
    check_eq("t5_post_nwr", wr_line.size(), 0);

    // 6: window wider than buffer clamps to 512 columns
    set_win(0, 0, 600, 1);
    clear_log();
    vs_pulse();
    line_gen(700, 0);
    check_eq("t6_nwr", wr_line.size(), 512);
    bad = 0;
    for (int k = 0; k < wr_col.size(); k++)
      if (wr_col[k] != k || wr_data[k] != pix(0, k) || wr_line[k] != 0) bad++;
    check_eq("t6_seq_errs", bad, 0);
    check_writes("t6_last", 511, 0, 511, pix(0, 511));
    check_eq("t6_nle", le_line.size(), 1);
    check_eq("t6_nfe", fe_cnt, 1);

    // 7: zero height never writes
    set_win(0, 0, 4, 0);
    clear_log();
    vs_pulse();
    line_gen(6, 13);
    check_eq("t7_nwr", wr_line.size(), 0);
    check_eq("t7_nle", le_line.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
